// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_fwd_ctrl
// Brief   : LEGv8 5-stage load-use stall, branch flush, operand/flag forwarding
//           selects and saturating stall/flush counters, evaluated beside ID.
// Revision: 1.0
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rn,
    input  logic [REG_W-1:0] i_id_rm,
    input  logic             i_id_use_rn,
    input  logic             i_id_use_rm,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_id_regwrite,
    input  logic             i_id_memread,
    input  logic             i_id_setflags,
    input  logic             i_id_fwd_en,
    input  logic             i_id_is_bcond,
    input  logic             i_id_br_taken,
    output logic             o_stall,
    output logic             o_flush_ifid,
    output logic [1:0]       o_fwda_sel,
    output logic [1:0]       o_fwdb_sel,
    output logic             o_flag_fwd,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [REG_W-1:0] c_zero_reg = REG_W'(ZERO_REG);

    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_regwrite;
    logic             r_ex_memread;
    logic             r_ex_setflags;
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_regwrite;
    logic [1:0]       r_fwda_sel;
    logic [1:0]       r_fwdb_sel;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic             w_ex_writer;
    logic             w_mem_writer;
    logic             w_stall;
    logic             w_flush;
    logic             w_flag_fwd;
    logic [1:0]       w_fwda_sel;
    logic [1:0]       w_fwdb_sel;

    assign w_ex_writer  = r_ex_valid  & r_ex_regwrite  & (r_ex_rd  != c_zero_reg);
    assign w_mem_writer = r_mem_valid & r_mem_regwrite & (r_mem_rd != c_zero_reg);

    assign w_stall = i_id_valid & w_ex_writer & r_ex_memread &
                     ((i_id_use_rn & (i_id_rn == r_ex_rd)) |
                      (i_id_use_rm & (i_id_rm == r_ex_rd)));

    // Stall wins over a taken branch; the branch is re-evaluated after the bubble.
    assign w_flush    = i_id_valid & i_id_br_taken & ~w_stall & ~reset;
    assign w_flag_fwd = i_id_valid & i_id_is_bcond & r_ex_valid & r_ex_setflags;

    // EX stage is checked first so the most recent producer wins.
    always_comb begin
        w_fwda_sel = 2'b00;
        w_fwdb_sel = 2'b00;
        if (i_id_use_rn & i_id_fwd_en & ~w_stall) begin
            if (w_ex_writer & (i_id_rn == r_ex_rd))
                w_fwda_sel = 2'b01;
            else if (w_mem_writer & (i_id_rn == r_mem_rd))
                w_fwda_sel = 2'b10;
        end
        if (i_id_use_rm & i_id_fwd_en & ~w_stall) begin
            if (w_ex_writer & (i_id_rm == r_ex_rd))
                w_fwdb_sel = 2'b01;
            else if (w_mem_writer & (i_id_rm == r_mem_rd))
                w_fwdb_sel = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_ex_setflags  <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_fwda_sel     <= 2'b00;
            r_fwdb_sel     <= 2'b00;
            r_stall_count  <= '0;
            r_flush_count  <= '0;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_ex_valid     <= i_id_valid & ~w_stall;
            if (!w_stall) begin
                r_ex_rd       <= i_id_rd;
                r_ex_regwrite <= i_id_regwrite;
                r_ex_memread  <= i_id_memread;
                r_ex_setflags <= i_id_setflags;
            end
            r_fwda_sel <= w_fwda_sel;
            r_fwdb_sel <= w_fwdb_sel;
            if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_flush && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign o_stall       = w_stall;
    assign o_flush_ifid  = w_flush;
    assign o_flag_fwd    = w_flag_fwd;
    assign o_fwda_sel    = r_fwda_sel;
    assign o_fwdb_sel    = r_fwdb_sel;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_fwd_ctrl
// Brief   : Directed plus random bench for hazard_fwd_ctrl against a
//           pipeline-list reference model.
// Revision: 1.0
// ============================================================================
module tb_hazard_fwd_ctrl;

    localparam int c_small_w = 6;
    localparam int c_small_max = (1 << c_small_w) - 1;

    typedef struct {
        bit v; logic [4:0] rn, rm, rd;
        bit urn, urm, rw, mr, sf, fe, bc, bt;
    } ins_t;

    typedef struct { bit v; logic [4:0] rd; bit rw, mr, sf; } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ins_t cur;

    logic        o_stall, o_flush, o_flag;
    logic [1:0]  o_fa, o_fb;
    logic [15:0] o_scnt, o_fcnt;
    logic        s_stall, s_flush, s_flag;
    logic [1:0]  s_fa, s_fb;
    logic [c_small_w-1:0] s_scnt, s_fcnt;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset(reset),
        .i_id_valid(cur.v), .i_id_rn(cur.rn), .i_id_rm(cur.rm),
        .i_id_use_rn(cur.urn), .i_id_use_rm(cur.urm), .i_id_rd(cur.rd),
        .i_id_regwrite(cur.rw), .i_id_memread(cur.mr), .i_id_setflags(cur.sf),
        .i_id_fwd_en(cur.fe), .i_id_is_bcond(cur.bc), .i_id_br_taken(cur.bt),
        .o_stall(o_stall), .o_flush_ifid(o_flush), .o_fwda_sel(o_fa), .o_fwdb_sel(o_fb),
        .o_flag_fwd(o_flag), .o_stall_count(o_scnt), .o_flush_count(o_fcnt)
    );

    hazard_fwd_ctrl #(.CNT_W(c_small_w)) dut_s (
        .clk(clk), .reset(reset),
        .i_id_valid(cur.v), .i_id_rn(cur.rn), .i_id_rm(cur.rm),
        .i_id_use_rn(cur.urn), .i_id_use_rm(cur.urm), .i_id_rd(cur.rd),
        .i_id_regwrite(cur.rw), .i_id_memread(cur.mr), .i_id_setflags(cur.sf),
        .i_id_fwd_en(cur.fe), .i_id_is_bcond(cur.bc), .i_id_br_taken(cur.bt),
        .o_stall(s_stall), .o_flush_ifid(s_flush), .o_fwda_sel(s_fa), .o_fwdb_sel(s_fb),
        .o_flag_fwd(s_flag), .o_stall_count(s_scnt), .o_flush_count(s_fcnt)
    );

    // Reference model: st[0] = EX occupant, st[1] = MEM occupant.
    ent_t st[2];
    logic [1:0] m_fa, m_fb;
    int m_sc, m_fc, m_sc_s, m_fc_s;
    int nchk = 0;
    int nfail = 0;

    function automatic ins_t nop();
        ins_t i = '{default: 0};
        return i;
    endfunction
    function automatic ins_t ldur(input int rd, input int rn);
        ins_t i = nop();
        i.v = 1; i.rd = 5'(rd); i.rn = 5'(rn); i.urn = 1; i.rw = 1; i.mr = 1; i.fe = 1;
        return i;
    endfunction
    function automatic ins_t alu(input int rd, input int rn, input int rm, input bit urm, input bit sf);
        ins_t i = nop();
        i.v = 1; i.rd = 5'(rd); i.rn = 5'(rn); i.rm = 5'(rm);
        i.urn = 1; i.urm = urm; i.rw = 1; i.sf = sf; i.fe = 1;
        return i;
    endfunction
    function automatic ins_t bcond(input bit taken);
        ins_t i = nop();
        i.v = 1; i.bc = 1; i.bt = taken; i.fe = 1;
        return i;
    endfunction

    function automatic bit is_wr(input ent_t e);
        return e.v && e.rw && (e.rd != 5'd31);
    endfunction
    function automatic bit e_stall();
        return cur.v && is_wr(st[0]) && st[0].mr &&
               ((cur.urn && cur.rn == st[0].rd) || (cur.urm && cur.rm == st[0].rd));
    endfunction
    function automatic logic [1:0] e_sel(input bit used, input logic [4:0] src);
        if (!used || !cur.fe || e_stall()) return 2'b00;
        for (int k = 0; k < 2; k++)
            if (is_wr(st[k]) && st[k].rd == src) return 2'(k + 1);
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        st[0] = '{default: 0}; st[1] = '{default: 0};
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_sc_s = 0; m_fc_s = 0;
    endtask

    task automatic check_all();
        bit es, ef, eg;
        es = e_stall();
        ef = cur.v && cur.bt && !es && !reset;
        eg = cur.v && cur.bc && st[0].v && st[0].sf;
        chk("stall", 32'(o_stall), 32'(es));
        chk("flush", 32'(o_flush), 32'(ef));
        chk("flag_fwd", 32'(o_flag), 32'(eg));
        chk("fwdA", 32'(o_fa), 32'(m_fa));
        chk("fwdB", 32'(o_fb), 32'(m_fb));
        chk("stall_count", 32'(o_scnt), 32'(m_sc));
        chk("flush_count", 32'(o_fcnt), 32'(m_fc));
        chk("stall_count_small", 32'(s_scnt), 32'(m_sc_s));
        chk("flush_count_small", 32'(s_fcnt), 32'(m_fc_s));
    endtask

    task automatic apply(input ins_t i);
        cur = i;
        @(negedge clk);
        check_all();
    endtask

    task automatic clock();
        bit es, ef;
        ent_t nx;
        @(posedge clk);
        es = e_stall();
        ef = cur.v && cur.bt && !es;
        m_fa = e_sel(cur.urn, cur.rn);
        m_fb = e_sel(cur.urm, cur.rm);
        nx.v = cur.v && !es; nx.rd = cur.rd; nx.rw = cur.rw; nx.mr = cur.mr; nx.sf = cur.sf;
        st[1] = st[0];
        st[0] = nx;
        m_sc   = sat(m_sc + int'(es), 65535);
        m_fc   = sat(m_fc + int'(ef), 65535);
        m_sc_s = sat(m_sc_s + int'(es), c_small_max);
        m_fc_s = sat(m_fc_s + int'(ef), c_small_max);
        #1;
    endtask

    task automatic step(input ins_t i);
        apply(i);
        clock();
    endtask

    function automatic logic [4:0] rreg();
        logic [4:0] pick [4] = '{5'd1, 5'd2, 5'd3, 5'd31};
        return pick[$urandom_range(0, 3)];
    endfunction

    initial begin
        ins_t r;
        cur = nop();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;

        // Load-use: one stall cycle, then MEM/WB forwarding for operand A.
        step(ldur(1, 2));
        apply(alu(2, 1, 3, 1, 1));
        chk("lu_stall", 32'(o_stall), 32'd1);
        clock();
        apply(alu(2, 1, 3, 1, 1));
        chk("lu_stall_once", 32'(o_stall), 32'd0);
        clock();
        apply(nop());
        chk("lu_fwdA", 32'(o_fa), 32'd2);
        chk("lu_count", 32'(o_scnt), 32'd1);
        clock();

        // Back-to-back ALU and EX-over-MEM priority.
        step(alu(4, 1, 0, 0, 0));
        step(alu(5, 4, 4, 1, 1));
        apply(nop());
        chk("alu_fwdA", 32'(o_fa), 32'd1);
        chk("alu_fwdB", 32'(o_fb), 32'd1);
        clock();
        step(alu(4, 1, 0, 0, 0));
        step(alu(4, 2, 0, 0, 0));
        step(alu(7, 4, 4, 1, 0));
        apply(nop());
        chk("prio_fwdA", 32'(o_fa), 32'd1);
        clock();

        // XZR never produces a hazard or a forward.
        step(alu(31, 1, 2, 1, 1));
        step(alu(6, 31, 31, 1, 1));
        step(ldur(31, 2));
        apply(alu(6, 31, 31, 1, 0));
        chk("xzr_stall", 32'(o_stall), 32'd0);
        clock();

        // Taken B.cond after SUBS, then coincident with a load-use stall.
        step(alu(9, 1, 2, 1, 1));
        apply(bcond(1));
        chk("br_flag", 32'(o_flag), 32'd1);
        chk("br_flush", 32'(o_flush), 32'd1);
        clock();
        step(ldur(1, 2));
        r = bcond(1); r.urn = 1; r.rn = 5'd1;
        apply(r);
        chk("br_stall_flush", 32'(o_flush), 32'd0);
        clock();
        step(nop());

        // Reset while a load-use stall is active.
        step(ldur(1, 2));
        cur = alu(2, 1, 3, 1, 1);
        @(negedge clk);
        chk("rst_pre_stall", 32'(o_stall), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_fwdA", 32'(o_fa), 32'd0);
        chk("rst_scnt", 32'(o_scnt), 32'd0);
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;

        // Saturation on the narrow-counter instance.
        for (int n = 0; n < 2 * (c_small_max + 4); n++) step(ldur(1, 1));
        chk("sat_stall", 32'(s_scnt), 32'(c_small_max));
        for (int n = 0; n < c_small_max + 4; n++) step(bcond(1));
        chk("sat_flush", 32'(s_fcnt), 32'(c_small_max));

        for (int n = 0; n < 400; n++) begin
            r.v   = ($urandom_range(0, 7) != 0);
            r.rn  = rreg(); r.rm = rreg(); r.rd = rreg();
            r.urn = $urandom_range(0, 1); r.urm = $urandom_range(0, 1);
            r.rw  = $urandom_range(0, 3) != 0; r.mr = $urandom_range(0, 2) == 0;
            r.sf  = $urandom_range(0, 1); r.fe = $urandom_range(0, 5) != 0;
            r.bc  = $urandom_range(0, 3) == 0; r.bt = $urandom_range(0, 4) == 0;
            step(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
